// File: rtl/piece_lock_pkg.sv
// Shared board geometry, piece codes, FSM states and request payload for piece_lock.
package piece_lock_pkg;

  localparam int unsigned BOARD_W    = 10;
  localparam int unsigned BOARD_H    = 24;
  localparam int unsigned SPAWN_ROWS = 4;
  localparam int unsigned COLOUR_W   = 6;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned COORD_W    = 7;

  localparam logic [COLOUR_W-1:0] EMPTY = '0;

  typedef enum logic [2:0] {
    PT_I   = 3'd0,
    PT_O   = 3'd1,
    PT_T   = 3'd2,
    PT_S   = 3'd3,
    PT_Z   = 3'd4,
    PT_J   = 3'd5,
    PT_L   = 3'd6,
    PT_BAD = 3'd7
  } piece_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_WAIT = 3'd2,
    ST_SAMP = 3'd3,
    ST_WR   = 3'd4,
    ST_WE   = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  typedef struct packed {
    logic                check_only;
    piece_t              piece_type;
    logic [1:0]          piece_rot;
    logic [4:0]          pos_x;
    logic [5:0]          pos_y;
    logic [COLOUR_W-1:0] colour;
  } req_t;

  // cy*BOARD_W + cx with the x10 built from two shifts; callers guarantee in-bounds cells.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] cy,
                                                  input logic [COORD_W-1:0] cx);
    return (ADDR_W'(cy) << 3) + (ADDR_W'(cy) << 1) + ADDR_W'(cx);
  endfunction

endpackage

// File: rtl/piece_lock_if.sv
// Request/result handshake and board RAM port of piece_lock.
interface piece_lock_if;

  logic                                  enable;
  logic                                  check_only;
  logic [2:0]                            piece_type;
  logic [1:0]                            piece_rot;
  logic [4:0]                            pos_x;
  logic [5:0]                            pos_y;
  logic [piece_lock_pkg::COLOUR_W-1:0]   colour;
  logic [piece_lock_pkg::COLOUR_W-1:0]   ram_Q;
  logic [piece_lock_pkg::ADDR_W-1:0]     ram_addr;
  logic [piece_lock_pkg::COLOUR_W-1:0]   ram_data;
  logic                                  ram_wren;
  logic                                  complete;
  logic                                  collision;
  logic                                  top_out;

  modport master (
    output enable, check_only, piece_type, piece_rot, pos_x, pos_y, colour, ram_Q,
    input  ram_addr, ram_data, ram_wren, complete, collision, top_out
  );

  modport slave (
    input  enable, check_only, piece_type, piece_rot, pos_x, pos_y, colour, ram_Q,
    output ram_addr, ram_data, ram_wren, complete, collision, top_out
  );

endinterface

// File: rtl/piece_lock_tetromino_cells.sv
// Combinational shape ROM: cell offsets (dx,dy) of a piece inside its 4x4 box, in row-major order.
module piece_lock_tetromino_cells
  import piece_lock_pkg::*;
(
  input  piece_t     piece_type,
  input  logic [1:0] piece_rot,
  input  logic [1:0] idx,
  output logic [1:0] dx_c,
  output logic [1:0] dy_c
);

  // Each nibble of a shape word is one cell {dy,dx}; cell 0 in the low nibble.
  function automatic logic [15:0] pick(input logic [1:0] r,
                                       input logic [15:0] s0, input logic [15:0] s1,
                                       input logic [15:0] s2, input logic [15:0] s3);
    logic [15:0] s;
    case (r)
      2'd0:    s = s0;
      2'd1:    s = s1;
      2'd2:    s = s2;
      default: s = s3;
    endcase
    return s;
  endfunction

  logic [15:0] shape_c;
  logic [3:0]  cell_c;

  always_comb begin
    shape_c = '0;
    case (piece_type)
      PT_I:    shape_c = pick(piece_rot, 16'h7654, 16'hEA62, 16'hBA98, 16'hD951);
      PT_O:    shape_c = pick(piece_rot, 16'h6521, 16'h6521, 16'h6521, 16'h6521);
      PT_T:    shape_c = pick(piece_rot, 16'h6541, 16'h9651, 16'h9654, 16'h9541);
      PT_S:    shape_c = pick(piece_rot, 16'h5421, 16'hA651, 16'h9865, 16'h9540);
      PT_Z:    shape_c = pick(piece_rot, 16'h6510, 16'h9652, 16'hA954, 16'h8541);
      PT_J:    shape_c = pick(piece_rot, 16'h6540, 16'h9521, 16'hA654, 16'h9851);
      PT_L:    shape_c = pick(piece_rot, 16'h6542, 16'hA951, 16'h8654, 16'h9510);
      default: shape_c = '0;
    endcase
  end

  assign cell_c = 4'(shape_c >> {idx, 2'b00});
  assign dx_c   = cell_c[1:0];
  assign dy_c   = cell_c[3:2];

endmodule

// File: rtl/piece_lock.sv
// Collision-checks the active tetromino against board RAM and, unless check_only,
// commits its four cells with the piece colour.
module piece_lock
  import piece_lock_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  piece_lock_if.slave bus
);

  state_t              state_q, state_d;
  req_t                req_q, req_d;
  logic [1:0]          idx_q, idx_d;
  logic                oob_q, oob_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COLOUR_W-1:0] data_q, data_d;
  logic                wren_q, wren_d;
  logic                complete_q, complete_d;
  logic                collision_q, collision_d;
  logic                top_out_q, top_out_d;

  logic [1:0]          dx_c, dy_c;
  logic [COORD_W-1:0]  cx_c, cy_c;
  logic                cell_oob_c;
  logic [ADDR_W-1:0]   cell_addr_c;

  piece_lock_tetromino_cells u_cells (
    .piece_type (req_q.piece_type),
    .piece_rot  (req_q.piece_rot),
    .idx        (idx_q),
    .dx_c       (dx_c),
    .dy_c       (dy_c)
  );

  // Board coordinates of the current cell; x is sign-extended so off-left cells read as negative.
  assign cx_c = COORD_W'($signed(req_q.pos_x)) + COORD_W'(dx_c);
  assign cy_c = COORD_W'(req_q.pos_y) + COORD_W'(dy_c);

  assign cell_oob_c = (req_q.piece_type == PT_BAD) || cx_c[COORD_W-1] ||
                      (cx_c >= COORD_W'(BOARD_W)) || (cy_c >= COORD_W'(BOARD_H));
  assign cell_addr_c = cell_addr(cy_c, cx_c);

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    idx_d       = idx_q;
    oob_d       = oob_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wren_d      = 1'b0;
    complete_d  = complete_q;
    collision_d = collision_q;
    top_out_d   = top_out_q;

    if (!bus.enable) begin
      // Dropping the request aborts anything in flight and clears all results.
      state_d     = ST_IDLE;
      idx_d       = '0;
      oob_d       = 1'b0;
      addr_d      = '0;
      data_d      = '0;
      complete_d  = 1'b0;
      collision_d = 1'b0;
      top_out_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_d.check_only = bus.check_only;
          req_d.piece_type = piece_t'(bus.piece_type);
          req_d.piece_rot  = bus.piece_rot;
          req_d.pos_x      = bus.pos_x;
          req_d.pos_y      = bus.pos_y;
          req_d.colour     = bus.colour;
          idx_d            = '0;
          oob_d            = 1'b0;
          state_d          = ST_ADDR;
        end
        ST_ADDR: begin
          oob_d = cell_oob_c;
          if (!cell_oob_c) begin
            addr_d = cell_addr_c;
          end
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          state_d = ST_SAMP;
        end
        ST_SAMP: begin
          if (oob_q || (bus.ram_Q != EMPTY)) begin
            collision_d = 1'b1;
            state_d     = ST_DONE;
          end else if (idx_q == 2'd3) begin
            idx_d   = '0;
            state_d = req_q.check_only ? ST_DONE : ST_WR;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_ADDR;
          end
        end
        ST_WR: begin
          addr_d = cell_addr_c;
          data_d = req_q.colour;
          wren_d = 1'b1;
          if (cy_c < COORD_W'(SPAWN_ROWS)) begin
            top_out_d = 1'b1;
          end
          state_d = ST_WE;
        end
        ST_WE: begin
          if (idx_q == 2'd3) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_WR;
          end
        end
        ST_DONE: begin
          complete_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      idx_q       <= '0;
      oob_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      wren_q      <= 1'b0;
      complete_q  <= 1'b0;
      collision_q <= 1'b0;
      top_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      idx_q       <= idx_d;
      oob_q       <= oob_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wren_q      <= wren_d;
      complete_q  <= complete_d;
      collision_q <= collision_d;
      top_out_q   <= top_out_d;
    end
  end

  assign bus.ram_addr  = addr_q;
  assign bus.ram_data  = data_q;
  assign bus.ram_wren  = wren_q;
  assign bus.complete  = complete_q;
  assign bus.collision = collision_q;
  assign bus.top_out   = top_out_q;

endmodule

// File: tb/tb_piece_lock.sv
// Bench for piece_lock: synchronous board RAM plus a bitmap-based reference model of the lock rules.
module tb_piece_lock;

  logic clk;
  logic resetn;

  piece_lock_if bus ();

  piece_lock dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shape bitmaps, bit (y*4+x) set for each occupied box cell; index = type*4 + rot.
  localparam logic [15:0] SHAPE [28] = '{
    16'h00F0, 16'h4444, 16'h0F00, 16'h2222,
    16'h0066, 16'h0066, 16'h0066, 16'h0066,
    16'h0072, 16'h0262, 16'h0270, 16'h0232,
    16'h0036, 16'h0462, 16'h0360, 16'h0231,
    16'h0063, 16'h0264, 16'h0630, 16'h0132,
    16'h0071, 16'h0226, 16'h0470, 16'h0322,
    16'h0074, 16'h0622, 16'h0170, 16'h0223
  };

  logic [5:0] mem [256];
  logic       clr_req;
  logic       poke_en;
  logic [7:0] poke_a;
  logic [5:0] poke_d;

  always @(posedge clk) begin
    if (clr_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (poke_en) begin
      mem[poke_a] <= poke_d;
    end else if (bus.ram_wren) begin
      mem[bus.ram_addr] <= bus.ram_data;
    end
    bus.ram_Q <= mem[bus.ram_addr];
  end

  int         n_checks;
  int         n_errors;
  logic [5:0] exp_board [256];
  int         exp_edge;
  bit         exp_coll;
  bit         exp_top;
  int         exp_wa [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic clear_board();
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    for (int i = 0; i < 256; i++) exp_board[i] = '0;
  endtask

  task automatic poke(input int a, input logic [5:0] v);
    poke_en = 1'b1;
    poke_a  = 8'(a);
    poke_d  = v;
    @(negedge clk);
    poke_en = 1'b0;
    exp_board[a] = v;
  endtask

  task automatic check_board(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_board[i]) bad++;
    check_eq(tag, bad, 0);
  endtask

  // Reference: find the first blocked cell in scan order, derive latency and the committed cells.
  task automatic model_op(input bit co, input int pt, input int rot, input int sx, input int sy,
                          input logic [5:0] col);
    int          cxs [4];
    int          cys [4];
    int          n;
    int          k;
    logic [15:0] shp;
    exp_wa.delete();
    exp_coll = 1'b0;
    exp_top  = 1'b0;
    shp = (pt < 7) ? SHAPE[pt*4 + rot] : 16'h0000;
    n = 0;
    for (int b = 0; b < 16; b++) begin
      if (shp[b] && n < 4) begin
        cxs[n] = sx + (b % 4);
        cys[n] = sy + (b / 4);
        n++;
      end
    end
    k = -1;
    for (int i = 0; i < 4; i++) begin
      if (k < 0) begin
        if (pt == 7) k = i;
        else if (cxs[i] < 0 || cxs[i] >= 10 || cys[i] >= 24) k = i;
        else if (exp_board[cys[i]*10 + cxs[i]] != 0) k = i;
      end
    end
    if (k >= 0) begin
      exp_coll = 1'b1;
      exp_edge = 3*k + 5;
    end else if (co) begin
      exp_edge = 14;
    end else begin
      exp_edge = 22;
      for (int i = 0; i < 4; i++) begin
        exp_wa.push_back(cys[i]*10 + cxs[i]);
        exp_board[cys[i]*10 + cxs[i]] = col;
        if (cys[i] < 4) exp_top = 1'b1;
      end
    end
  endtask

  task automatic drive_req(input bit co, input int pt, input int rot, input logic [4:0] px,
                           input logic [5:0] py, input logic [5:0] col);
    bus.check_only = co;
    bus.piece_type = 3'(pt);
    bus.piece_rot  = 2'(rot);
    bus.pos_x      = px;
    bus.pos_y      = py;
    bus.colour     = col;
    bus.enable     = 1'b1;
  endtask

  // One full request: run to complete, check against the model, then release enable.
  task automatic run_op(input string name, input bit co, input int pt, input int rot,
                        input logic [4:0] px, input logic [5:0] py, input logic [5:0] col,
                        output int got_edge, output bit moved);
    int         sx;
    int         npulse;
    logic [7:0] addr0;
    sx = $signed(px);
    model_op(co, pt, rot, sx, int'(py), col);
    drive_req(co, pt, rot, px, py, col);
    got_edge = -1;
    npulse   = 0;
    moved    = 1'b0;
    addr0    = bus.ram_addr;
    for (int e = 1; e <= 40; e++) begin
      if (got_edge < 0) begin
        @(negedge clk);
        if (e == 1) begin
          bus.check_only = 1'($urandom);
          bus.piece_type = 3'($urandom);
          bus.piece_rot  = 2'($urandom);
          bus.pos_x      = 5'($urandom);
          bus.pos_y      = 6'($urandom);
          bus.colour     = 6'($urandom);
        end
        if (bus.ram_addr !== addr0) moved = 1'b1;
        if (bus.ram_wren === 1'b1) begin
          if (npulse < exp_wa.size()) begin
            check_eq({name, ":wr_addr"}, bus.ram_addr, exp_wa[npulse]);
            check_eq({name, ":wr_data"}, bus.ram_data, col);
          end
          npulse++;
        end
        if (bus.complete === 1'b1) got_edge = e;
      end
    end
    check_eq({name, ":latency"}, got_edge, exp_edge);
    check_eq({name, ":collision"}, bus.collision, exp_coll);
    check_eq({name, ":top_out"}, bus.top_out, exp_top);
    check_eq({name, ":wren_pulses"}, npulse, exp_wa.size());
    @(negedge clk);
    check_eq({name, ":hold"}, {bus.complete, bus.collision, bus.ram_wren}, {1'b1, exp_coll, 1'b0});
    bus.enable = 1'b0;
    @(negedge clk);
    check_eq({name, ":release"}, {bus.complete, bus.collision, bus.top_out, bus.ram_wren}, 4'b0000);
    check_board({name, ":board"});
  endtask

  int         got_e;
  bit         mv;
  int         sx_r;
  int         npulse_a;
  logic [4:0] px_r;
  logic [5:0] py_r;

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    clr_req        = 1'b0;
    poke_en        = 1'b0;
    poke_a         = '0;
    poke_d         = '0;
    resetn         = 1'b0;
    bus.enable     = 1'b0;
    bus.check_only = 1'b0;
    bus.piece_type = '0;
    bus.piece_rot  = '0;
    bus.pos_x      = '0;
    bus.pos_y      = '0;
    bus.colour     = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_addr", bus.ram_addr, 0);
    check_eq("rst_flags", {bus.ram_data, bus.ram_wren, bus.complete, bus.collision, bus.top_out}, 0);
    resetn = 1'b1;
    @(negedge clk);
    clear_board();

    // O piece clean lock on an empty board
    run_op("t1_lock", 1'b0, 1, 0, 5'd4, 6'd10, 6'h12, got_e, mv);
    check_eq("t1_edge", got_e, 22);
    check_eq("t1_cells", {mem[105], mem[106], mem[115], mem[116]}, {4{6'h12}});

    // Same piece blocked by its last cell
    clear_board();
    poke(116, 6'd3);
    run_op("t2_block", 1'b0, 1, 0, 5'd4, 6'd10, 6'h12, got_e, mv);
    check_eq("t2_edge", got_e, 14);

    // I piece hanging off the left edge
    clear_board();
    run_op("t3_left", 1'b0, 0, 0, 5'b11111, 6'd5, 6'h05, got_e, mv);
    check_eq("t3_edge", got_e, 5);
    check_eq("t3_addr_moved", mv, 1'b0);

    // I piece on the bottom row, then one row too low
    clear_board();
    run_op("t4_bottom", 1'b0, 0, 0, 5'd6, 6'd22, 6'h2A, got_e, mv);
    check_eq("t4_cells", {mem[236], mem[237], mem[238], mem[239]}, {4{6'h2A}});
    run_op("t4_below", 1'b0, 0, 0, 5'd6, 6'd23, 6'h2A, got_e, mv);
    check_eq("t4b_edge", got_e, 5);

    // Spawn-zone lock flags top_out; check_only never does
    clear_board();
    run_op("t5_top", 1'b0, 1, 0, 5'd0, 6'd2, 6'h07, got_e, mv);
    check_eq("t5_top_cells", {mem[21], mem[22], mem[31], mem[32]}, {4{6'h07}});
    clear_board();
    run_op("t5_chk", 1'b1, 1, 0, 5'd0, 6'd2, 6'h07, got_e, mv);
    check_eq("t5_chk_edge", got_e, 14);

    // Abort after the second write pulse; the two written cells stay written
    clear_board();
    drive_req(1'b0, 1, 0, 5'd4, 6'd10, 6'h12);
    npulse_a = 0;
    for (int e = 1; e <= 40; e++) begin
      if (npulse_a < 2) begin
        @(negedge clk);
        if (bus.ram_wren === 1'b1) npulse_a++;
      end
    end
    check_eq("t6_pulses_seen", npulse_a, 2);
    bus.enable = 1'b0;
    @(negedge clk);
    check_eq("t6_abort", {bus.ram_wren, bus.complete, bus.collision, bus.top_out}, 4'b0000);
    exp_board[105] = 6'h12;
    exp_board[106] = 6'h12;
    check_board("t6_board");
    run_op("t6_reenable", 1'b0, 1, 0, 5'd4, 6'd10, 6'h12, got_e, mv);
    check_eq("t6_reenable_edge", got_e, 5);

    // Asynchronous reset in the middle of a check
    clear_board();
    drive_req(1'b0, 1, 0, 5'd4, 6'd10, 6'h12);
    repeat (3) @(negedge clk);
    check_eq("t6_pre_rst_addr", bus.ram_addr, 105);
    resetn = 1'b0;
    #1;
    check_eq("t6_async_rst",
             {bus.ram_addr, bus.ram_data, bus.ram_wren, bus.complete, bus.collision, bus.top_out}, 0);
    bus.enable = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_op("t6_after_rst", 1'b0, 2, 1, 5'd3, 6'd12, 6'h21, got_e, mv);

    // Randomized requests on a board that fills up between occasional clears
    clear_board();
    for (int n = 0; n < 160; n++) begin
      if ($urandom_range(0, 15) == 0) clear_board();
      if ($urandom_range(0, 3) == 0) poke(int'($urandom_range(0, 239)), 6'($urandom_range(1, 63)));
      if ($urandom_range(0, 4) == 0) begin
        px_r = 5'($urandom);
      end else begin
        sx_r = int'($urandom_range(0, 10)) - 1;
        px_r = 5'(sx_r);
      end
      py_r = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'($urandom_range(0, 23));
      run_op("rand", 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 3)), px_r, py_r, 6'($urandom_range(1, 63)), got_e, mv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
